// File: rtl/hsv_core_pkg.sv
// Shared core types for the issue/writeback boundary.
// Writeback arbiter types and source indices live here too.
package hsv_core_pkg;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] word;
  typedef logic [31:0] reg_mask;

  typedef struct packed {
    logic    wr_rd;
    reg_addr rd_addr;
    word     rd_data;
  } wb_req_t;

  localparam int WB_PORT_ALU         = 0;
  localparam int WB_PORT_BRANCH      = 1;
  localparam int WB_PORT_CTRL_STATUS = 2;
  localparam int WB_PORT_MEM         = 3;

endpackage

// File: rtl/hsv_core_wb_rr_pick.sv
// Rotate-priority picker: first valid at or after ptr_i, wrapping.
// Reusable for any issue-side arbiter; ptr_i tied to 0 gives fixed priority.
module hsv_core_wb_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [PTR_W:0] NP = (PTR_W+1)'(N);

  logic [PTR_W:0] pos;

  // Walk farthest-first so the nearest valid slot is written last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (pos >= NP) pos = pos - NP;
      if (valid_i[pos[PTR_W-1:0]]) begin
        idx_o = pos[PTR_W-1:0];
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/hsv_core_wb_arbiter.sv
// Writeback arbiter onto the single regfile write port.
// HSV_WB_FIXED_PRIO_EN selects fixed priority (port 0 highest).
module hsv_core_wb_arbiter
  import hsv_core_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic                      clk_core,
  input  logic                      rst_core_n,
  input  logic                      flush_req,
  output logic                      flush_ack,
  input  logic [N_PORTS-1:0]        req_valid_i,
  output logic [N_PORTS-1:0]        req_ready_o,
  input  logic [N_PORTS-1:0][4:0]   req_rd_addr,
  input  logic [N_PORTS-1:0][31:0]  req_rd_data,
  input  logic [N_PORTS-1:0]        req_wr_rd,
  output logic [4:0]                wr_addr,
  output logic [31:0]               wr_data,
  output logic                      wr_en,
  output logic [31:0]               commit_mask,
  output logic [N_PORTS-1:0]        wb_busy_o
);

  localparam int PTR_W = $clog2(N_PORTS);

  wb_req_t            req [N_PORTS];
  wb_req_t            sel;
  logic [N_PORTS-1:0] gnt;
  logic [PTR_W-1:0]   gidx;
  logic               any;
  logic               xfer;
  logic [PTR_W-1:0]   ptr;

  logic    wr_en_q, wr_en_d;
  reg_addr wr_addr_q, wr_addr_d;
  word     wr_data_q, wr_data_d;
  reg_mask mask_q, mask_d;
  logic    ack_q, ack_d;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      req[i] = '{wr_rd:   req_wr_rd[i],
                 rd_addr: req_rd_addr[i],
                 rd_data: req_rd_data[i]};
    end
  end

`ifdef HSV_WB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  assign ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush_req) begin
      rr_ptr_d = '0;
    end else if (xfer) begin
      if (gidx == PTR_W'(N_PORTS - 1)) rr_ptr_d = '0;
      else rr_ptr_d = gidx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
`endif

  hsv_core_wb_rr_pick #(
    .N     (N_PORTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .any_o   (any)
  );

  // Ready is also gated by reset so nothing is accepted while held.
  assign req_ready_o = gnt & {N_PORTS{~flush_req & rst_core_n}};
  assign wb_busy_o   = req_valid_i & ~req_ready_o;
  assign xfer        = any & ~flush_req;
  assign sel         = req[gidx];

  always_comb begin
    wr_en_d   = 1'b0;
    mask_d    = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ack_d     = flush_req;
    if (xfer) begin
      wr_addr_d = sel.rd_addr;
      wr_data_d = sel.rd_data;
      wr_en_d   = sel.wr_rd & (sel.rd_addr != '0);
      mask_d    = wr_en_d ? (reg_mask'(1) << sel.rd_addr) : '0;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign commit_mask = mask_q;
  assign flush_ack   = ack_q;

endmodule

// File: tb/tb_hsv_core_wb_arbiter.sv
// Bench for hsv_core_wb_arbiter: directed plan plus random traffic.
// Reference model tracks pointer and expected commit as plain integers.
module tb_hsv_core_wb_arbiter;
  import hsv_core_pkg::*;

  localparam int N = 4;

  logic              clk_core = 1'b0;
  logic              rst_core_n = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_ack;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0][4:0] req_rd_addr = '0;
  logic [N-1:0][31:0] req_rd_data = '0;
  logic [N-1:0]      req_wr_rd = '0;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [31:0]       commit_mask;
  logic [N-1:0]      wb_busy_o;

  hsv_core_wb_arbiter dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rd_addr (req_rd_addr),
    .req_rd_data (req_rd_data),
    .req_wr_rd   (req_wr_rd),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .commit_mask (commit_mask),
    .wb_busy_o   (wb_busy_o)
  );

  always #5 clk_core = ~clk_core;

  int n_chk = 0;
  int n_fail = 0;

  int          m_ptr = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_en = 1'b0;
  logic        m_ack = 1'b0;
  logic [31:0] m_mask = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_pick();
    int base;
    if (flush_req || req_valid_i == '0) return -1;
`ifdef HSV_WB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < N; k++)
      if (req_valid_i[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  // Starts just after a rising edge with inputs already driven.
  task automatic cycle(output int g);
    logic [N-1:0] exp_rdy;
    g = m_pick();
    #1;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("ready", req_ready_o, exp_rdy);
    chk("busy", wb_busy_o, req_valid_i & ~exp_rdy);
    @(posedge clk_core);
    m_ack = flush_req;
    if (flush_req) begin
      m_ptr = 0;
      m_en = 1'b0;
      m_mask = '0;
    end else if (g >= 0) begin
      m_ptr  = (g + 1) % N;
      m_addr = req_rd_addr[g];
      m_data = req_rd_data[g];
      m_en   = req_wr_rd[g] && (m_addr != 0);
      m_mask = m_en ? (32'h1 << m_addr) : 32'h0;
    end else begin
      m_en = 1'b0;
      m_mask = '0;
    end
    #1;
    chk("wr_en", wr_en, m_en);
    chk("commit_mask", commit_mask, m_mask);
    chk("flush_ack", flush_ack, m_ack);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
  endtask

  logic [N-1:0] pend;
  logic [31:0]  t2_exp [5];
  int g;

  initial begin
    // reset state, requests present
    req_valid_i = 4'hF;
    #3;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_mask", commit_mask, 0);
    chk("rst_ack", flush_ack, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    req_valid_i = '0;
    #9 rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;

    // single request
    req_valid_i = 4'b0001;
    req_rd_addr[0] = 5'd5;
    req_rd_data[0] = 32'hDEADBEEF;
    req_wr_rd = 4'b0001;
    cycle(g);
    chk("t1_mask", commit_mask, 32'h20);
    chk("t1_data", wr_data, 32'hDEADBEEF);

    // pointer back to 0, then all four valid
    flush_req = 1'b1;
    cycle(g);
    flush_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_rd_addr[i] = 5'(i + 1);
      req_rd_data[i] = 32'h100 + 32'(i);
    end
    req_wr_rd = 4'hF;
    req_valid_i = 4'hF;
`ifdef HSV_WB_FIXED_PRIO_EN
    t2_exp = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2};
`else
    t2_exp = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h2};
`endif
    for (int i = 0; i < 5; i++) begin
      cycle(g);
      chk("t2_mask", commit_mask, t2_exp[i]);
    end

    // x0 suppression and retire-only
    req_valid_i = 4'b1000;
    req_rd_addr[3] = 5'd0;
    req_wr_rd = 4'b1000;
    cycle(g);
    chk("t3_x0_en", wr_en, 0);
    req_valid_i = 4'b0010;
    req_rd_addr[1] = 5'd7;
    req_wr_rd = 4'b0000;
    cycle(g);
    chk("t3_ret_mask", commit_mask, 0);

    // flush with ports 1 and 2 pending
    req_wr_rd = 4'hF;
    req_valid_i = 4'b0110;
    flush_req = 1'b1;
    cycle(g);
    cycle(g);
    flush_req = 1'b0;
    #1;
`ifndef HSV_WB_FIXED_PRIO_EN
    chk("t4_first", req_ready_o, 4'b0010);
`endif
    cycle(g);

    // wrap-around from pointer 3
    req_valid_i = 4'b0100;
    cycle(g);
    req_valid_i = 4'b1001;
    cycle(g);
    cycle(g);
    req_valid_i = 4'hF;
    cycle(g);

    // random traffic; sources hold until accepted
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1) == 1)) begin
          pend[i] = 1'b1;
          req_rd_addr[i] = 5'($urandom);
          req_rd_data[i] = $urandom;
          req_wr_rd[i] = ($urandom_range(3) != 0);
        end
      end
      req_valid_i = pend;
      flush_req = ($urandom_range(9) == 0);
      cycle(g);
      if (g >= 0) pend[g] = 1'b0;
    end
    flush_req = 1'b0;

    // async reset while a write is registered
    req_valid_i = 4'b0001;
    req_rd_addr[0] = 5'd9;
    req_wr_rd = 4'b0001;
    cycle(g);
    chk("t6_pre_en", wr_en, 1);
    #2 rst_core_n = 1'b0;
    #1;
    chk("t6_en", wr_en, 0);
    chk("t6_mask", commit_mask, 0);
    chk("t6_ack", flush_ack, 0);
    chk("t6_ready", req_ready_o, 0);
    @(posedge clk_core);
    #2;
    chk("t6_ready_hold", req_ready_o, 0);
    chk("t6_en_hold", wr_en, 0);
    req_valid_i = '0;
    rst_core_n = 1'b1;
    m_ptr = 0;
    m_addr = '0;
    m_data = '0;
    m_en = 1'b0;
    m_mask = '0;
    m_ack = 1'b0;
    @(posedge clk_core);
    #1;
    cycle(g);
    req_valid_i = 4'hF;
    cycle(g);
    cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hsv_core_wb_arbiter.md
Name: hsv_core_wb_arbiter

Overview:
- Shares the single issue-stage register-file write port between the execution-unit writeback sources: ALU, branch, control-status and memory.
- Arbitrates valid/ready requests and registers the winner onto the regfile write port (wr_addr/wr_data/wr_en).
- Produces the commit_mask feedback that the issue hazard logic uses to clear pending-destination bits.
- Sits between the exec-mem units and the issue stage's regfile/commit inputs.

Parameters:
- N_PORTS, 4, number of writeback requesters; index 0=ALU, 1=branch, 2=ctrl-status, 3=mem.
- PTR_W, $clog2(N_PORTS), width of the round-robin pointer; derived, not overridden.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- flush_req  in  1  pipeline flush request
- flush_ack  out  1  flush acknowledge
- req_valid_i  in  N_PORTS  per-source writeback valid
- req_ready_o  out  N_PORTS  per-source grant/accept
- req_rd_addr  in  N_PORTS x 5 (reg_addr)  destination register per source
- req_rd_data  in  N_PORTS x 32 (word)  result data per source
- req_wr_rd  in  N_PORTS  1 = instruction writes rd; 0 = retire-only (store, non-link branch)
- wr_addr  out  5  regfile write address
- wr_data  out  32  regfile write data
- wr_en  out  1  regfile write enable
- commit_mask  out  32 (reg_mask)  one-hot of register committed this cycle
- wb_busy_o  out  N_PORTS  per-source "requesting but not granted" (debug/perf)

Behaviour:
- Reset, asynchronous, from rst_core_n: wr_en=0, wr_addr=0, wr_data=0, commit_mask=0, rr_ptr=0, flush_ack=0. req_ready_o=0 while in reset.
- Grant is combinational, one cycle:
  - the first i with req_valid_i[i]=1, searching from rr_ptr upward with wrap-around modulo N_PORTS;
  - at most one bit of req_ready_o is set; req_ready_o[i] = grant[i] & ~flush_req.
- Handshake:
  - transfer on req_valid_i[i] & req_ready_o[i];
  - a source holds valid and data stable until accepted;
  - the arbiter never de-asserts ready on a held request except under flush or after losing arbitration.
- Pointer: on a transfer from port g, rr_ptr <= (g+1) mod N_PORTS. There is no transfer when no port is valid, and rr_ptr holds.
- Output register, latency 1: the cycle after a transfer from port g:
  - wr_addr = req_rd_addr[g], wr_data = req_rd_data[g];
  - wr_en = req_wr_rd[g] & (req_rd_addr[g] != 0);
  - commit_mask = wr_en ? (1 << wr_addr) : 0.
- x0 rule: writes to x0 are suppressed, with wr_en=0 and commit_mask=0; the request is still accepted and retired.
- Idle cycle (no transfer): wr_en=0 and commit_mask=0. wr_addr and wr_data hold their previous values.
- commit_mask and wr_en are asserted in the same cycle; the regfile and hazard logic observe a consistent commit.
- Flush:
  - while flush_req=1, no grants, and the output register is loaded with wr_en=0, commit_mask=0;
  - flush_ack <= flush_req, registered;
  - rr_ptr is reset to 0 on the first flush cycle.
- Simultaneous flush and valid: flush wins, and no port is accepted.
- wb_busy_o[i] = req_valid_i[i] & ~req_ready_o[i].
- Reset mid-operation: the in-flight registered write is discarded, and wr_en drops asynchronously.

Optional Feature:
- Macro HSV_WB_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin, and the lowest index wins (ALU highest). rr_ptr is removed; a permanently valid port 0 may starve the others.
- Undefined (default): round-robin as specified above.

Decomposition:
- hsv_core_pkg holds:
  - reg_addr, word and reg_mask (existing);
  - new wb_req_t = {wr_rd, rd_addr, rd_data};
  - localparam WB_PORT_ALU/BRANCH/CTRL_STATUS/MEM = 0..3.
- Ports may be flattened into wb_req_t arrays.
- One sub-module: hsv_core_wb_rr_pick, a combinational rotate-priority picker taking valid and ptr and returning a one-hot grant plus an encoded index. This unit is reusable for other issue-side arbiters.

Test Plan:
1. Single request: port 0 valid with rd=5, data=0xDEADBEEF, wr_rd=1.
   -> ready_o[0]=1 the same cycle.
   -> Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, commit_mask=0x00000020.
2. All four ports valid continuously with rd=1,2,3,4, rr_ptr=0.
   -> Grants follow 0,1,2,3,0 on consecutive cycles.
   -> commit_mask sequence 0x2,0x4,0x8,0x10,0x2.
   -> With HSV_WB_FIXED_PRIO_EN defined: port 0 is granted every cycle, and wb_busy_o=0b1110.
3. x0 and retire-only:
   - port 3 with rd=0, wr_rd=1 -> accepted; next cycle wr_en=0, commit_mask=0;
   - port 1 with rd=7, wr_rd=0 -> accepted, wr_en=0, commit_mask=0.
4. Flush: ports 1 and 2 valid and flush_req=1 for 2 cycles.
   -> req_ready_o=0 throughout; wr_en=0 for 2 cycles.
   -> flush_ack high 1 cycle delayed; rr_ptr=0 afterwards; port 1 is granted first after flush drops.
5. Wrap-around: rr_ptr=3 with ports 0 and 3 valid -> port 3 granted, then port 0, and rr_ptr becomes 1.
6. Async reset asserted mid-transfer while wr_en=1.
   -> wr_en, commit_mask and flush_ack go to 0 immediately without a clock edge.
   -> req_ready_o=0 until reset is released.
